mod_regread: RTL and testbench
==============================

// Module: mod_regread
// PURPOSE
//  Register-read (operand fetch) stage: the consumer side of the writeback-to-regfile interface.
//  Owns the 16x64 architectural register file and a per-register pending-write scoreboard.
//  Accepts decoded instructions, reads up to two source operands (with writeback bypass) and
//  stalls on RAW hazards. Issues into a registered ID->EX pipeline slot with valid/ready.
// PARAMETERS
//  NREGS   16  number of architectural registers (index width fixed at 4)
//  XLEN    64  register/data width
//  PEND_W  2   scoreboard counter width; max in-flight writes per reg = 2**PEND_W-1
// PORTS
//  clk            in   1      clock, all state on rising edge
//  reset          in   1      asynchronous, active-high reset
//  id_valid       in   1      decoded instruction present
//  id_ready       out  1      stage accepts instruction this cycle
//  id_opcode      in   8      opcode, passed through to EX
//  id_src_a       in   4      source A register index (regByte)
//  id_src_b       in   4      source B register index (rmByte)
//  id_use_a       in   1      source A is read
//  id_use_b       in   1      source B is read
//  id_dst_mask    in   NREGS  registers this instr will write (incl. implicit rsp/rdx)
//  ex_valid       out  1      ID->EX slot holds an instruction
//  ex_ready       in   1      EX consumes slot this cycle
//  ex_opcode      out  8      registered opcode
//  ex_a           out  XLEN   registered operand A (0 if !use_a)
//  ex_b           out  XLEN   registered operand B (0 if !use_b)
//  ex_dst_mask    out  NREGS  registered destination mask
//  wb0_en/wb1_en  in   1      writeback write-port enables
//  wb0_idx/wb1_idx in  4      write-port register indices
//  wb0_data/wb1_data in XLEN  write-port data
//  wb_retire_mask in   NREGS  one pulse per retiring instr; clears its pending writes
//  regfile_o      out  NREGS*XLEN  flat register-file snapshot (debug/sim)
//  err_sb         out  1      sticky: retire on register with pend==0
// BEHAVIOUR
//  - Reset (async): regfile all 0, pend all 0, ex_valid=0, ex_opcode/ex_a/ex_b/ex_dst_mask=0,
//    err_sb=0. Reset mid-operation discards in-flight slot and all scoreboard state.
//  - Regfile write on clk edge; wb0 then wb1 applied, wb1 wins on equal index.
//  - Read bypass: rd(i) = wb1 data if wb1_en&&wb1_idx==i, else wb0 if match, else regfile[i].
//  - pend_next[i] = pend[i] - retire_mask[i] (retire first, combinational view this cycle).
//  - hazard = (use_a && pend_next[src_a]!=0) || (use_b && pend_next[src_b]!=0)
//             || any i: dst_mask[i] && pend_next[i]==2**PEND_W-1 (WAW saturation).
//  - id_ready = !reset && !hazard && (!ex_valid || ex_ready); fire = id_valid && id_ready.
//  - Latency 1: on fire, ex_* load bypassed operands next edge, ex_valid<=1.
//    ex_ready && !fire -> ex_valid<=0. ex_valid && !ex_ready -> ex_* held stable.
//  - Scoreboard edge update: pend[i] <= pend_next[i] + (fire && dst_mask[i]); same-cycle
//    retire+issue on one reg leaves count unchanged. Retire with pend==0: count stays 0, err_sb<=1.
//  - Retire must coincide with or follow final data write for that instr; a retire cycle's
//    data is delivered via bypass, so RAW stall releases in the retire cycle itself.
//  - No flush; squash is handled upstream by withholding id_valid.
// TESTING
//  1 reset; wb0 R3=0x1234; next cycle issue src_a=3,use_a -> ex_valid=1, ex_a=0x1234 one edge later.
//  2 issue I1 dst_mask=1<<5; I2 src_a=5 -> id_ready=0 until retire cycle with wb0 R5=0xAA and
//    retire bit5 -> id_ready=1 that cycle, ex_a=0xAA.
//  3 same cycle wb0 R0=1, wb1 R2=2 (mul pair); then wb0 R4=7, wb1 R4=9 -> regfile_o R0=1,R2=2,R4=9.
//  4 ex_valid=1, ex_ready=0 for 5 cycles with id_valid=1 -> id_ready=0, ex_* unchanged throughout.
//  5 three issues dst_mask bit4, no retire -> 4th writer stalls; three retires -> pend[4]=0, issues.
//  6 reset asserted with pend[4]=2, ex_valid=1 -> immediately ex_valid=0, pend clear;
//    retire bit7 with pend 0 -> err_sb=1 and stays set until reset.

Source files
------------

// File: rtl/mod_regread.sv
// Register-read stage: 16xXLEN register file, per-register pending-write scoreboard,
// writeback bypass on operand reads, RAW/WAW stall, and a registered ID->EX slot.
module mod_regread #(
   parameter int unsigned NREGS  = 16,
   parameter int unsigned XLEN   = 64,
   parameter int unsigned PEND_W = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    id_valid,
   output logic                    id_ready,
   input  logic [7:0]              id_opcode,
   input  logic [3:0]              id_src_a,
   input  logic [3:0]              id_src_b,
   input  logic                    id_use_a,
   input  logic                    id_use_b,
   input  logic [NREGS-1:0]        id_dst_mask,
   output logic                    ex_valid,
   input  logic                    ex_ready,
   output logic [7:0]              ex_opcode,
   output logic [XLEN-1:0]         ex_a,
   output logic [XLEN-1:0]         ex_b,
   output logic [NREGS-1:0]        ex_dst_mask,
   input  logic                    wb0_en,
   input  logic [3:0]              wb0_idx,
   input  logic [XLEN-1:0]         wb0_data,
   input  logic                    wb1_en,
   input  logic [3:0]              wb1_idx,
   input  logic [XLEN-1:0]         wb1_data,
   input  logic [NREGS-1:0]        wb_retire_mask,
   output logic [NREGS*XLEN-1:0]   regfile_o,
   output logic                    err_sb
);

   localparam logic [PEND_W-1:0] PendMax = '1;

   logic [XLEN-1:0]   rf_q [NREGS];
   logic [PEND_W-1:0] pend_q [NREGS];
   logic [PEND_W-1:0] pend_nx [NREGS];
   logic [PEND_W-1:0] pend_d [NREGS];

   logic              ex_valid_q, ex_valid_d;
   logic [7:0]        ex_opcode_q, ex_opcode_d;
   logic [XLEN-1:0]   ex_a_q, ex_a_d;
   logic [XLEN-1:0]   ex_b_q, ex_b_d;
   logic [NREGS-1:0]  ex_dst_q, ex_dst_d;
   logic              err_q;

   logic [XLEN-1:0]   op_a, op_b;
   logic              retire_err, waw_sat, raw_haz, hazard, fire;

   // Operand read with writeback bypass; wb1 has priority as it wins the regfile write.
   always_comb begin
      op_a = '0;
      if (id_use_a) begin
         if (wb1_en && wb1_idx == id_src_a)      op_a = wb1_data;
         else if (wb0_en && wb0_idx == id_src_a) op_a = wb0_data;
         else                                    op_a = rf_q[id_src_a];
      end
   end

   always_comb begin
      op_b = '0;
      if (id_use_b) begin
         if (wb1_en && wb1_idx == id_src_b)      op_b = wb1_data;
         else if (wb0_en && wb0_idx == id_src_b) op_b = wb0_data;
         else                                    op_b = rf_q[id_src_b];
      end
   end

   // Retires are applied before the hazard check so a retiring writer releases its readers.
   always_comb begin
      retire_err = 1'b0;
      waw_sat    = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         pend_nx[i] = pend_q[i];
         if (wb_retire_mask[i]) begin
            if (pend_q[i] == '0) retire_err = 1'b1;
            else                 pend_nx[i] = pend_q[i] - PEND_W'(1);
         end
         if (id_dst_mask[i] && pend_nx[i] == PendMax) waw_sat = 1'b1;
      end
   end

   assign raw_haz  = (id_use_a && pend_nx[id_src_a] != '0) ||
                     (id_use_b && pend_nx[id_src_b] != '0);
   assign hazard   = raw_haz || waw_sat;
   assign id_ready = !reset && !hazard && (!ex_valid_q || ex_ready);
   assign fire     = id_valid && id_ready;

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         pend_d[i] = pend_nx[i] + PEND_W'(fire && id_dst_mask[i]);
      end
   end

   always_comb begin
      ex_valid_d  = ex_valid_q;
      ex_opcode_d = ex_opcode_q;
      ex_a_d      = ex_a_q;
      ex_b_d      = ex_b_q;
      ex_dst_d    = ex_dst_q;
      if (fire) begin
         ex_valid_d  = 1'b1;
         ex_opcode_d = id_opcode;
         ex_a_d      = op_a;
         ex_b_d      = op_b;
         ex_dst_d    = id_dst_mask;
      end else if (ex_ready) begin
         ex_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i]   <= '0;
            pend_q[i] <= '0;
         end
         ex_valid_q  <= 1'b0;
         ex_opcode_q <= '0;
         ex_a_q      <= '0;
         ex_b_q      <= '0;
         ex_dst_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         if (wb0_en) rf_q[wb0_idx] <= wb0_data;
         if (wb1_en) rf_q[wb1_idx] <= wb1_data;
         for (int i = 0; i < NREGS; i++) begin
            pend_q[i] <= pend_d[i];
         end
         ex_valid_q  <= ex_valid_d;
         ex_opcode_q <= ex_opcode_d;
         ex_a_q      <= ex_a_d;
         ex_b_q      <= ex_b_d;
         ex_dst_q    <= ex_dst_d;
         if (retire_err) err_q <= 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regfile_o[i*XLEN +: XLEN] = rf_q[i];
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_opcode   = ex_opcode_q;
   assign ex_a        = ex_a_q;
   assign ex_b        = ex_b_q;
   assign ex_dst_mask = ex_dst_q;
   assign err_sb      = err_q;

endmodule

// File: tb/tb_mod_regread.sv
// Scoreboard bench for mod_regread: issues push expected EX slots, a monitor pops on consume.
module tb_mod_regread;

   localparam int unsigned NREGS = 16;
   localparam int unsigned XLEN  = 64;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  id_valid, id_ready;
   logic [7:0]            id_opcode;
   logic [3:0]            id_src_a, id_src_b;
   logic                  id_use_a, id_use_b;
   logic [NREGS-1:0]      id_dst_mask;
   logic                  ex_valid, ex_ready;
   logic [7:0]            ex_opcode;
   logic [XLEN-1:0]       ex_a, ex_b;
   logic [NREGS-1:0]      ex_dst_mask;
   logic                  wb0_en, wb1_en;
   logic [3:0]            wb0_idx, wb1_idx;
   logic [XLEN-1:0]       wb0_data, wb1_data;
   logic [NREGS-1:0]      wb_retire_mask;
   logic [NREGS*XLEN-1:0] regfile_o;
   logic                  err_sb;

   typedef struct packed {
      logic [7:0]       op;
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [NREGS-1:0] dst;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   mod_regread dut (
      .clk            (clk),
      .reset          (reset),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_opcode      (id_opcode),
      .id_src_a       (id_src_a),
      .id_src_b       (id_src_b),
      .id_use_a       (id_use_a),
      .id_use_b       (id_use_b),
      .id_dst_mask    (id_dst_mask),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .ex_opcode      (ex_opcode),
      .ex_a           (ex_a),
      .ex_b           (ex_b),
      .ex_dst_mask    (ex_dst_mask),
      .wb0_en         (wb0_en),
      .wb0_idx        (wb0_idx),
      .wb0_data       (wb0_data),
      .wb1_en         (wb1_en),
      .wb1_idx        (wb1_idx),
      .wb1_data       (wb1_data),
      .wb_retire_mask (wb_retire_mask),
      .regfile_o      (regfile_o),
      .err_sb         (err_sb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_ex: got opcode %0h, expected no slot", ex_opcode);
            end else begin
               e = exp_q.pop_front();
               chk("ex_opcode", 64'(ex_opcode), 64'(e.op));
               chk("ex_a", ex_a, e.a);
               chk("ex_b", ex_b, e.b);
               chk("ex_dst_mask", 64'(ex_dst_mask), 64'(e.dst));
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [7:0] op, input logic [3:0] sa, input logic [3:0] sb,
                         input logic ua, input logic ub, input logic [NREGS-1:0] dst);
      id_valid    = 1'b1;
      id_opcode   = op;
      id_src_a    = sa;
      id_src_b    = sb;
      id_use_a    = ua;
      id_use_b    = ub;
      id_dst_mask = dst;
   endtask

   task automatic push_exp(input logic [7:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [NREGS-1:0] dst);
      exp_t e;
      e.op  = op;
      e.a   = a;
      e.b   = b;
      e.dst = dst;
      exp_q.push_back(e);
   endtask

   // Drives one instruction for a single cycle, expecting it to be accepted.
   task automatic issue(input string name, input logic [7:0] op, input logic [3:0] sa,
                        input logic [3:0] sb, input logic ua, input logic ub,
                        input logic [NREGS-1:0] dst, input logic [XLEN-1:0] ea,
                        input logic [XLEN-1:0] eb);
      set_id(op, sa, sb, ua, ub, dst);
      #1;
      chk({name, "_id_ready"}, 64'(id_ready), 64'd1);
      push_exp(op, ea, eb, dst);
      tick();
      id_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      id_valid = 1'b0; id_opcode = '0; id_src_a = '0; id_src_b = '0;
      id_use_a = 1'b0; id_use_b = 1'b0; id_dst_mask = '0; ex_ready = 1'b1;
      wb0_en = 1'b0; wb0_idx = '0; wb0_data = '0;
      wb1_en = 1'b0; wb1_idx = '0; wb1_data = '0; wb_retire_mask = '0;
      fork
         monitor();
      join_none

      #2;
      chk("rst_ex_valid", 64'(ex_valid), 64'd0);
      chk("rst_ex_a", ex_a, 64'd0);
      chk("rst_err_sb", 64'(err_sb), 64'd0);
      chk("rst_id_ready", 64'(id_ready), 64'd0);
      chk("rst_rf_r3", regfile_o[3*XLEN +: XLEN], 64'd0);
      tick();
      tick();
      reset = 1'b0;

      // 1: write R3 then read it the following cycle
      wb0_en = 1'b1; wb0_idx = 4'd3; wb0_data = 64'h1234;
      tick();
      wb0_en = 1'b0;
      issue("t1", 8'h11, 4'd3, 4'd0, 1'b1, 1'b0, '0, 64'h1234, 64'd0);
      chk("t1_ex_valid", 64'(ex_valid), 64'd1);
      chk("t1_ex_a", ex_a, 64'h1234);
      tick();

      // 2: RAW stall on R5 released by the retire cycle via bypass
      issue("t2_i1", 8'h21, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0020, 64'd0, 64'd0);
      set_id(8'h22, 4'd5, 4'd0, 1'b1, 1'b0, '0);
      repeat (2) begin
         #1;
         chk("t2_stall_id_ready", 64'(id_ready), 64'd0);
         tick();
      end
      wb0_en = 1'b1; wb0_idx = 4'd5; wb0_data = 64'hAA; wb_retire_mask = 16'h0020;
      #1;
      chk("t2_release_id_ready", 64'(id_ready), 64'd1);
      push_exp(8'h22, 64'hAA, 64'd0, '0);
      tick();
      id_valid = 1'b0; wb0_en = 1'b0; wb_retire_mask = '0;

      // 3: dual write ports, wb1 wins on equal index
      wb0_en = 1'b1; wb0_idx = 4'd0; wb0_data = 64'd1;
      wb1_en = 1'b1; wb1_idx = 4'd2; wb1_data = 64'd2;
      tick();
      wb0_idx = 4'd4; wb0_data = 64'd7;
      wb1_idx = 4'd4; wb1_data = 64'd9;
      tick();
      wb0_en = 1'b0; wb1_en = 1'b0;
      chk("t3_rf_r0", regfile_o[0*XLEN +: XLEN], 64'd1);
      chk("t3_rf_r2", regfile_o[2*XLEN +: XLEN], 64'd2);
      chk("t3_rf_r4", regfile_o[4*XLEN +: XLEN], 64'd9);
      chk("t3_rf_r5", regfile_o[5*XLEN +: XLEN], 64'hAA);

      // 4: EX backpressure holds the slot stable and blocks ID
      ex_ready = 1'b0;
      issue("t4_j1", 8'h41, 4'd4, 4'd2, 1'b1, 1'b1, '0, 64'd9, 64'd2);
      set_id(8'h42, 4'd0, 4'd0, 1'b1, 1'b0, '0);
      repeat (5) begin
         #1;
         chk("t4_id_ready", 64'(id_ready), 64'd0);
         chk("t4_ex_valid", 64'(ex_valid), 64'd1);
         chk("t4_ex_opcode", 64'(ex_opcode), 64'h41);
         chk("t4_ex_a", ex_a, 64'd9);
         chk("t4_ex_b", ex_b, 64'd2);
         tick();
      end
      ex_ready = 1'b1;
      #1;
      chk("t4_j2_id_ready", 64'(id_ready), 64'd1);
      push_exp(8'h42, 64'd1, 64'd0, '0);
      tick();
      id_valid = 1'b0;

      // 5: WAW saturation at three pending writes to R4
      issue("t5_k1", 8'h51, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0010, 64'd0, 64'd0);
      issue("t5_k2", 8'h52, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0010, 64'd0, 64'd0);
      issue("t5_k3", 8'h53, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0010, 64'd0, 64'd0);
      set_id(8'h54, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0010);
      repeat (2) begin
         #1;
         chk("t5_sat_id_ready", 64'(id_ready), 64'd0);
         tick();
      end
      id_valid = 1'b0;
      wb_retire_mask = 16'h0010;
      repeat (3) tick();
      wb_retire_mask = '0;
      issue("t5_rd", 8'h55, 4'd4, 4'd0, 1'b1, 1'b0, '0, 64'd9, 64'd0);
      issue("t5_k4", 8'h56, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0010, 64'd0, 64'd0);
      set_id(8'h57, 4'd4, 4'd0, 1'b1, 1'b0, '0);
      #1;
      chk("t5_raw_id_ready", 64'(id_ready), 64'd0);
      id_valid = 1'b0;
      tick();

      // 6: async reset mid-operation, then retire on an idle register
      ex_ready = 1'b0;
      issue("t6_w", 8'h61, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0010, 64'd0, 64'd0);
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("t6_rst_ex_valid", 64'(ex_valid), 64'd0);
      chk("t6_rst_ex_opcode", 64'(ex_opcode), 64'd0);
      chk("t6_rst_ex_dst", 64'(ex_dst_mask), 64'd0);
      chk("t6_rst_rf_r4", regfile_o[4*XLEN +: XLEN], 64'd0);
      tick();
      reset = 1'b0;
      ex_ready = 1'b1;
      issue("t6_rd", 8'h62, 4'd4, 4'd0, 1'b1, 1'b0, '0, 64'd0, 64'd0);
      wb_retire_mask = 16'h0080;
      #1;
      chk("t6_err_before", 64'(err_sb), 64'd0);
      tick();
      wb_retire_mask = '0;
      chk("t6_err_set", 64'(err_sb), 64'd1);
      repeat (3) tick();
      chk("t6_err_sticky", 64'(err_sb), 64'd1);
      reset = 1'b1;
      #1;
      chk("t6_err_cleared", 64'(err_sb), 64'd0);
      tick();
      reset = 1'b0;
      repeat (2) tick();
      chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
